sonar_uc: RTL and testbench
===========================

Name: sonar_uc

Overview:
Control unit for the sonar sweep. It sits directly upstream of the sonar datapath and drives that datapath's medicao, transmissao, sel_rom, sel_transmissao and sel_posicao inputs. It consumes the datapath's sensor_pronto and serial_pronto. For each servo position it waits for the servo to settle, triggers one distance measurement, then sends an 8-character frame (angle, separator, distance, terminator) over serial. The servo sweeps back and forth over positions 0..7.

Parameters:
T_SERVO, 50_000_000, settle time in clock cycles after each position change (1 s at 50 MHz).
T_TIMEOUT, 3_000_000, maximum clock cycles to wait for sensor_pronto before abandoning the measurement.
N_CHARS, 8, characters per frame; sel_transmissao runs 0..N_CHARS-1.

Ports:
clock  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-low reset.
ligar  in  1  level; 1 = run sweep, 0 = stop.
sensor_pronto  in  1  one-cycle pulse from the datapath: measurement done.
serial_pronto  in  1  one-cycle pulse from the datapath: character sent.
medicao  out  1  one-cycle pulse: start measurement.
transmissao  out  1  one-cycle pulse: start sending character sel_transmissao.
sel_posicao  out  3  servo position index.
sel_rom  out  3  angle ROM address; always equals sel_posicao.
sel_transmissao  out  3  index of the character being sent.
timeout  out  1  one-cycle pulse when a measurement is abandoned.
fim_posicao  out  1  one-cycle pulse when a position's frame is complete.
db_estado  out  4  current state encoding (debug).

Behaviour:
- Reset (reset=0 at a clock edge):
  - state INICIAL; all outputs 0; sweep direction = up; timers cleared.
  - Reset wins over every other event in any state, including mid-frame.
- State encodings (db_estado):
  - INICIAL=0, ESPERA_SERVO=1, MEDE=2, AGUARDA_MEDIDA=3, TRANSMITE=4, AGUARDA_SERIAL=5, PROXIMO_CHAR=6, PROXIMA_POSICAO=7, FALHA=8.
  - Unused encodings go to INICIAL.
- INICIAL:
  - Holds sel_posicao at its current value.
  - ligar=1 → ESPERA_SERVO with the settle timer cleared.
- ESPERA_SERVO:
  - Settle timer increments each cycle; advance to MEDE after exactly T_SERVO cycles in this state.
  - ligar=0 here → INICIAL; sel_posicao is kept.
- MEDE:
  - Exactly one cycle with medicao=1.
  - Clears the timeout timer and sel_transmissao.
  - → AGUARDA_MEDIDA.
- AGUARDA_MEDIDA:
  - sensor_pronto=1 → TRANSMITE.
  - Timeout timer reaching T_TIMEOUT-1 with no sensor_pronto → FALHA.
  - If sensor_pronto and timeout occur in the same cycle, sensor_pronto wins.
- FALHA:
  - One cycle with timeout=1.
  - → PROXIMA_POSICAO; no frame is sent.
- TRANSMITE:
  - One cycle with transmissao=1 → AGUARDA_SERIAL.
- AGUARDA_SERIAL:
  - Waits indefinitely for serial_pronto, then → PROXIMO_CHAR.
- PROXIMO_CHAR:
  - If sel_transmissao = N_CHARS-1 → PROXIMA_POSICAO.
  - Otherwise sel_transmissao increments → TRANSMITE.
- PROXIMA_POSICAO:
  - One cycle with fim_posicao=1; sel_posicao updates (sweep rule below).
  - ligar=1 → ESPERA_SERVO.
  - ligar=0 → INICIAL.
- ligar=0 in MEDE through PROXIMO_CHAR is ignored; the frame completes first.
- Pulse inputs arriving outside their waiting state are ignored and not remembered. This includes a sensor_pronto in the same cycle as medicao.
- Sweep rule:
  - Direction up: 6→7 switches direction to down; otherwise +1.
  - Direction down: 1→0 switches direction to up; otherwise -1.
  - Sequence from reset: 0,1,…,7,6,…,0,1,… No wrap 7→0.
- Output timing and widths:
  - medicao, transmissao, timeout and fim_posicao are registered Moore outputs; each is high only in its own state.
  - sel_* outputs are registers.
  - Timers are unsigned and wide enough for the largest parameter (≥26 bits at the defaults).

Test Plan:
(Bench overrides T_SERVO=10, T_TIMEOUT=20.)
1. Reset low 2 cycles, ligar=1 → all outputs 0, db_estado=0; 10 cycles after ESPERA_SERVO entry, medicao pulses once with sel_posicao=0, sel_rom=0.
2. sensor_pronto 5 cycles after medicao; serial_pronto 3 cycles after each transmissao → exactly 8 transmissao pulses with sel_transmissao 0..7 in order, then fim_posicao once, then sel_posicao=1.
3. No sensor_pronto → timeout pulses 20 cycles after entering AGUARDA_MEDIDA; zero transmissao pulses; fim_posicao; sel_posicao advances.
4. Run 16 positions → sel_posicao sequence 0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1.
5. Drop ligar during the frame at character 3 → characters 4..7 still sent, then INICIAL with sel_posicao=1. Drop ligar during ESPERA_SERVO → immediate INICIAL, no medicao.
6. Assert reset during AGUARDA_SERIAL → next cycle db_estado=0, sel_posicao=0, sel_transmissao=0; a stray serial_pronto afterwards causes no pulse.

Source files
------------

// File: rtl/sonar_uc.sv
// Sonar sweep control unit: settles the servo, triggers one measurement per position,
// sends an N_CHARS frame over serial, and sweeps positions 0..7 back and forth.
module sonar_uc #(
    parameter int unsigned T_SERVO   = 50_000_000,
    parameter int unsigned T_TIMEOUT = 3_000_000,
    parameter int unsigned N_CHARS   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       sensor_pronto,
    input  logic       serial_pronto,
    output logic       medicao,
    output logic       transmissao,
    output logic [2:0] sel_posicao,
    output logic [2:0] sel_rom,
    output logic [2:0] sel_transmissao,
    output logic       timeout,
    output logic       fim_posicao,
    output logic [3:0] db_estado
);

    localparam int unsigned T_MAX = (T_SERVO > T_TIMEOUT) ? T_SERVO : T_TIMEOUT;
    localparam int unsigned TMR_W = $clog2(T_MAX + 1);

    typedef enum logic [3:0] {
        INICIAL         = 4'd0,
        ESPERA_SERVO    = 4'd1,
        MEDE            = 4'd2,
        AGUARDA_MEDIDA  = 4'd3,
        TRANSMITE       = 4'd4,
        AGUARDA_SERIAL  = 4'd5,
        PROXIMO_CHAR    = 4'd6,
        PROXIMA_POSICAO = 4'd7,
        FALHA           = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       pos_q, pos_d;
    logic [2:0]       chr_q, chr_d;
    logic             dir_down_q, dir_down_d;
    logic             med_q, tx_q, to_q, fim_q;

    // Next-state, timer, character index and sweep position
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        pos_d      = pos_q;
        chr_d      = chr_q;
        dir_down_d = dir_down_q;
        case (state_q)
            INICIAL: begin
                if (ligar) begin
                    state_d = ESPERA_SERVO;
                    tmr_d   = '0;
                end
            end
            ESPERA_SERVO: begin
                if (!ligar) begin
                    state_d = INICIAL;
                end else if (tmr_q == TMR_W'(T_SERVO - 1)) begin
                    state_d = MEDE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            MEDE: begin
                tmr_d   = '0;
                chr_d   = '0;
                state_d = AGUARDA_MEDIDA;
            end
            AGUARDA_MEDIDA: begin
                // A measurement arriving on the last allowed cycle still counts
                if (sensor_pronto) begin
                    state_d = TRANSMITE;
                end else if (tmr_q == TMR_W'(T_TIMEOUT - 1)) begin
                    state_d = FALHA;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            FALHA:     state_d = PROXIMA_POSICAO;
            TRANSMITE: state_d = AGUARDA_SERIAL;
            AGUARDA_SERIAL: begin
                if (serial_pronto) begin
                    state_d = PROXIMO_CHAR;
                end
            end
            PROXIMO_CHAR: begin
                if (chr_q == 3'(N_CHARS - 1)) begin
                    state_d = PROXIMA_POSICAO;
                end else begin
                    chr_d   = chr_q + 3'd1;
                    state_d = TRANSMITE;
                end
            end
            PROXIMA_POSICAO: begin
                // Bounce at the ends: the direction flips on the step that reaches 7 or 0
                if (!dir_down_q) begin
                    pos_d = pos_q + 3'd1;
                    if (pos_q == 3'd6) begin
                        dir_down_d = 1'b1;
                    end
                end else begin
                    pos_d = pos_q - 3'd1;
                    if (pos_q == 3'd1) begin
                        dir_down_d = 1'b0;
                    end
                end
                tmr_d   = '0;
                state_d = ligar ? ESPERA_SERVO : INICIAL;
            end
            default: state_d = INICIAL;
        endcase
    end

    // State and Moore output registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= INICIAL;
            tmr_q      <= '0;
            pos_q      <= '0;
            chr_q      <= '0;
            dir_down_q <= 1'b0;
            med_q      <= 1'b0;
            tx_q       <= 1'b0;
            to_q       <= 1'b0;
            fim_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            pos_q      <= pos_d;
            chr_q      <= chr_d;
            dir_down_q <= dir_down_d;
            med_q      <= (state_d == MEDE);
            tx_q       <= (state_d == TRANSMITE);
            to_q       <= (state_d == FALHA);
            fim_q      <= (state_d == PROXIMA_POSICAO);
        end
    end

    assign medicao         = med_q;
    assign transmissao     = tx_q;
    assign timeout         = to_q;
    assign fim_posicao     = fim_q;
    assign sel_posicao     = pos_q;
    assign sel_rom         = pos_q;
    assign sel_transmissao = chr_q;
    assign db_estado       = state_q;

endmodule

// File: tb/tb_sonar_uc.sv
// Self-checking bench for sonar_uc with shortened settle and timeout times.
module tb_sonar_uc;

    localparam int unsigned T_SERVO   = 10;
    localparam int unsigned T_TIMEOUT = 20;
    localparam int          NVEC      = 13;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ligar = 1'b0;
    logic       sp    = 1'b0;
    logic       sr    = 1'b0;
    logic       medicao, transmissao, timeout, fim_posicao;
    logic [2:0] sel_posicao, sel_rom, sel_transmissao;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_fail   = 0;
    int tx_cnt   = 0;
    int med_cnt  = 0;
    int to_cnt   = 0;

    typedef struct {
        logic       rst_n;
        logic       ligar;
        logic       sp;
        logic       sr;
        logic [3:0] st;
        logic       med;
        logic       tx;
        logic       to;
        logic       fim;
        logic [2:0] pos;
        logic [2:0] chr;
    } vec_t;

    vec_t vecs [NVEC];
    int   exp_pos [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    sonar_uc #(
        .T_SERVO  (T_SERVO),
        .T_TIMEOUT(T_TIMEOUT),
        .N_CHARS  (8)
    ) dut (
        .clock          (clk),
        .reset          (rst_n),
        .ligar          (ligar),
        .sensor_pronto  (sp),
        .serial_pronto  (sr),
        .medicao        (medicao),
        .transmissao    (transmissao),
        .sel_posicao    (sel_posicao),
        .sel_rom        (sel_rom),
        .sel_transmissao(sel_transmissao),
        .timeout        (timeout),
        .fim_posicao    (fim_posicao),
        .db_estado      (db_estado)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (transmissao === 1'b1) tx_cnt++;
        if (medicao === 1'b1)     med_cnt++;
        if (timeout === 1'b1)     to_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] st, input int budget, input string name);
        int n = 0;
        while (db_estado !== st && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(db_estado), 32'(st));
    endtask

    // Called with MEDE just observed; ends with PROXIMA_POSICAO observed
    task automatic run_measure(input bit give_sensor, input int drop_char, input bit stray);
        int tx0 = tx_cnt;
        int to0 = to_cnt;
        int n;
        check("medicao_pulse", 32'(medicao), 32'd1);
        if (give_sensor) begin
            repeat (4) tick();
            check("aguarda_medida", 32'(db_estado), 32'd3);
            sp = 1'b1;
            tick();
            sp = 1'b0;
            for (int c = 0; c < 8; c++) begin
                check($sformatf("char%0d.state", c), 32'(db_estado), 32'd4);
                check($sformatf("char%0d.tx", c), 32'(transmissao), 32'd1);
                check($sformatf("char%0d.sel", c), 32'(sel_transmissao), 32'(c));
                if (c == drop_char) ligar = 1'b0;
                tick();
                check($sformatf("char%0d.wait", c), 32'(db_estado), 32'd5);
                tick();
                sr = 1'b1;
                tick();
                sr = 1'b0;
                check($sformatf("char%0d.next", c), 32'(db_estado), 32'd6);
                tick();
            end
            check("frame_tx_count", 32'(tx_cnt - tx0), 32'd8);
        end else begin
            if (stray) sp = 1'b1;
            tick();
            sp = 1'b0;
            n = 1;
            while (db_estado === 4'd3 && n < 100) begin
                tick();
                n++;
            end
            check("timeout_latency", 32'(n - 1), 32'(T_TIMEOUT));
            check("falha_state", 32'(db_estado), 32'd8);
            check("timeout_pulse", 32'(timeout), 32'd1);
            tick();
            check("timeout_count", 32'(to_cnt - to0), 32'd1);
            check("timeout_no_tx", 32'(tx_cnt - tx0), 32'd0);
        end
        check("proxima_state", 32'(db_estado), 32'd7);
        check("fim_pulse", 32'(fim_posicao), 32'd1);
    endtask

    initial begin
        int m0;
        int t0;

        // Reset for two cycles, then ESPERA_SERVO for T_SERVO cycles, then MEDE
        for (int i = 0; i < NVEC; i++) begin
            vecs[i] = '{rst_n: (i >= 2), ligar: 1'b1, sp: 1'b0, sr: 1'b0,
                        st: (i < 2) ? 4'd0 : (i < 12) ? 4'd1 : 4'd2,
                        med: (i == 12), tx: 1'b0, to: 1'b0, fim: 1'b0,
                        pos: 3'd0, chr: 3'd0};
        end

        for (int i = 0; i < NVEC; i++) begin
            rst_n = vecs[i].rst_n;
            ligar = vecs[i].ligar;
            sp    = vecs[i].sp;
            sr    = vecs[i].sr;
            tick();
            check($sformatf("vec%0d.state", i), 32'(db_estado), 32'(vecs[i].st));
            check($sformatf("vec%0d.med", i), 32'(medicao), 32'(vecs[i].med));
            check($sformatf("vec%0d.tx", i), 32'(transmissao), 32'(vecs[i].tx));
            check($sformatf("vec%0d.to", i), 32'(timeout), 32'(vecs[i].to));
            check($sformatf("vec%0d.fim", i), 32'(fim_posicao), 32'(vecs[i].fim));
            check($sformatf("vec%0d.pos", i), 32'(sel_posicao), 32'(vecs[i].pos));
            check($sformatf("vec%0d.rom", i), 32'(sel_rom), 32'(vecs[i].pos));
            check($sformatf("vec%0d.chr", i), 32'(sel_transmissao), 32'(vecs[i].chr));
        end

        // Full frame at position 0
        run_measure(1'b1, -1, 1'b0);
        tick();
        check("after_frame.state", 32'(db_estado), 32'd1);
        check("after_frame.pos", 32'(sel_posicao), 32'd1);

        // Timeout-only positions covering the whole bounce sequence
        for (int i = 1; i < 16; i++) begin
            wait_state(4'd2, 40, $sformatf("pos%0d.mede", i));
            check($sformatf("pos%0d.sel_posicao", i), 32'(sel_posicao), 32'(exp_pos[i]));
            check($sformatf("pos%0d.sel_rom", i), 32'(sel_rom), 32'(exp_pos[i]));
            run_measure(1'b0, -1, (i == 1));
        end

        // Dropping ligar while settling returns immediately without measuring
        tick();
        check("settle.state", 32'(db_estado), 32'd1);
        repeat (3) tick();
        ligar = 1'b0;
        tick();
        check("drop_settle.state", 32'(db_estado), 32'd0);
        check("drop_settle.pos", 32'(sel_posicao), 32'd2);
        m0 = med_cnt;
        repeat (T_SERVO + 5) tick();
        check("drop_settle.no_medicao", 32'(med_cnt - m0), 32'd0);
        check("drop_settle.idle", 32'(db_estado), 32'd0);

        // Reset mid-frame, then a stray serial_pronto must be ignored
        ligar = 1'b1;
        wait_state(4'd2, 40, "rst_test.mede");
        check("rst_test.pos", 32'(sel_posicao), 32'd2);
        repeat (4) tick();
        sp = 1'b1;
        tick();
        sp = 1'b0;
        check("rst_test.transmite", 32'(db_estado), 32'd4);
        tick();
        check("rst_test.aguarda_serial", 32'(db_estado), 32'd5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ligar = 1'b0;
        check("rst_mid.state", 32'(db_estado), 32'd0);
        check("rst_mid.pos", 32'(sel_posicao), 32'd0);
        check("rst_mid.chr", 32'(sel_transmissao), 32'd0);
        check("rst_mid.tx", 32'(transmissao), 32'd0);
        t0 = tx_cnt;
        sr = 1'b1;
        tick();
        sr = 1'b0;
        repeat (3) tick();
        check("stray_serial.no_tx", 32'(tx_cnt - t0), 32'd0);
        check("stray_serial.state", 32'(db_estado), 32'd0);

        // Dropping ligar mid-frame still completes the frame, then idles at the next position
        ligar = 1'b1;
        wait_state(4'd2, 40, "drop_frame.mede");
        check("drop_frame.pos0", 32'(sel_posicao), 32'd0);
        run_measure(1'b1, 3, 1'b0);
        tick();
        check("drop_frame.state", 32'(db_estado), 32'd0);
        check("drop_frame.pos", 32'(sel_posicao), 32'd1);
        m0 = med_cnt;
        repeat (T_SERVO + 5) tick();
        check("drop_frame.idle", 32'(db_estado), 32'd0);
        check("drop_frame.no_medicao", 32'(med_cnt - m0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
